dmem_sized: RTL and testbench

DMEM_SIZED -- requirements
Module: dmem_sized

---
 rtl/dm_pkg.sv | 30 +++
 rtl/dmem_sized_if.sv | 26 ++
 rtl/dm_align.sv | 51 +++++
 rtl/dmem_sized.sv | 152 +++++++++++++++
 tb/tb_dmem_sized.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// Shared encodings for the sized data memory: access sizes, FSM states and
// the alignment rule used to reject bad requests.
package dm_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // A request is rejected when its size is reserved or its address is not
  // a multiple of the access width.
  function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size_e'(size))
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = |lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_sized_if.sv
// Request/response bus of the sized data memory; master issues requests,
// slave (the memory) answers one cycle later.
interface dmem_sized_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_sext;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_align.sv
// Lane steering for the sized memory: store data is replicated into lanes with
// a byte-enable mask, load data is pulled from its lane and extended.
module dm_align
  import dm_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_lo_i,
  input  logic [31:0] st_wdata_i,
  output logic [31:0] st_data_o,
  output logic [3:0]  st_be_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_lo_i,
  input  logic        ld_sext_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Merge happens in the memory through byte enables, so no old word is read.
  always_comb begin
    st_data_o = st_wdata_i;
    st_be_o   = 4'b0000;
    case (size_e'(st_size_i))
      SZ_BYTE: begin
        st_data_o = {4{st_wdata_i[7:0]}};
        st_be_o   = 4'b0001 << st_lo_i;
      end
      SZ_HALF: begin
        st_data_o = {2{st_wdata_i[15:0]}};
        st_be_o   = st_lo_i[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: st_be_o = 4'b1111;
      default: st_be_o = 4'b0000;
    endcase
  end

  always_comb begin
    ld_byte   = 8'(ld_word_i >> {ld_lo_i, 3'b000});
    ld_half   = ld_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
    ld_data_o = '0;
    case (size_e'(ld_size_i))
      SZ_BYTE: ld_data_o = {{24{ld_sext_i & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data_o = {{16{ld_sext_i & ld_half[15]}}, ld_half};
      SZ_WORD: ld_data_o = ld_word_i;
      default: ld_data_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_sized.sv
// Byte/half/word data memory with fixed one-cycle response and an optional
// clear-on-reset sweep; storage is four byte-lane RAMs with registered reads.
module dmem_sized
  import dm_pkg::*;
#(
  parameter int ADDR_W         = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  dmem_sized_if.slave bus,
  output logic        init_done
);

  localparam int WA = ADDR_W - 2;
  localparam int DEPTH = 2 ** WA;
  localparam logic [WA-1:0] LAST_IDX = WA'(DEPTH - 1);
  localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;

  state_e        state_q, state_d;
  logic [WA-1:0] cnt_q, cnt_d;
  logic          req_ready;
  logic          accept;
  logic          req_bad;
  logic [WA-1:0] word_idx;

  logic          wr_en;
  logic [WA-1:0] wr_idx;
  logic [31:0]   wr_data;
  logic [3:0]    wr_be;
  logic          rd_en;
  logic [31:0]   rd_word;

  logic [31:0]   st_data;
  logic [3:0]    st_be;
  logic [31:0]   ld_data;

  logic          resp_valid_q;
  logic          resp_err_q;
  logic          ld_q;
  logic [1:0]    ld_size_q;
  logic [1:0]    ld_lo_q;
  logic          ld_sext_q;
  logic          init_done_q;

  assign accept   = bus.req_valid & req_ready;
  assign req_bad  = is_bad_access(bus.req_size, bus.req_addr[1:0]);
  assign word_idx = bus.req_addr[ADDR_W-1:2];
  assign rd_en    = accept & ~bus.req_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + WA'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN:  req_ready = ~rst;
      default: state_d = ST_INIT;
    endcase
  end

  // The clear sweep owns the write port while INIT is active.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = word_idx;
    wr_data = st_data;
    wr_be   = st_be;
    if (state_q == ST_INIT) begin
      wr_en   = ~rst;
      wr_idx  = cnt_q;
      wr_data = '0;
      wr_be   = 4'b1111;
    end else if (accept && bus.req_we && !req_bad) begin
      wr_en = 1'b1;
    end
  end

  dm_align u_align (
    .st_size_i  (bus.req_size),
    .st_lo_i    (bus.req_addr[1:0]),
    .st_wdata_i (bus.req_wdata),
    .st_data_o  (st_data),
    .st_be_o    (st_be),
    .ld_size_i  (ld_size_q),
    .ld_lo_i    (ld_lo_q),
    .ld_sext_i  (ld_sext_q),
    .ld_word_i  (rd_word),
    .ld_data_o  (ld_data)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] lane_rd_q;

    always_ff @(posedge clk) begin
      if (wr_en && wr_be[gi]) begin
        lane_mem[wr_idx] <= wr_data[8*gi +: 8];
      end
      if (rd_en) begin
        lane_rd_q <= lane_mem[word_idx];
      end
    end

    assign rd_word[8*gi +: 8] = lane_rd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      ld_q         <= 1'b0;
      ld_size_q    <= 2'b00;
      ld_lo_q      <= 2'b00;
      ld_sext_q    <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      resp_valid_q <= accept;
      resp_err_q   <= accept & req_bad;
      ld_q         <= accept & ~bus.req_we & ~req_bad;
      init_done_q  <= (state_d == ST_RUN);
      if (accept) begin
        ld_size_q <= bus.req_size;
        ld_lo_q   <= bus.req_addr[1:0];
        ld_sext_q <= bus.req_sext;
      end
    end
  end

  // Stores and rejected requests answer with zero data.
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = ld_q ? ld_data : 32'h0;
  assign bus.req_ready  = req_ready;
  assign init_done      = init_done_q;

endmodule

// File: tb/tb_dmem_sized.sv
// Directed and random requests against a byte-array model of the memory;
// every response is compared one cycle after its request is issued.
module tb_dmem_sized;

  logic clk = 1'b0;
  logic rst;
  logic init_done;

  int nchk = 0;
  int nerr = 0;

  logic [7:0] mbytes [64];

  bit          pend_v;
  logic [31:0] pend_rdata;
  bit          pend_err;
  string       pend_tag;

  dmem_sized_if #(.ADDR_W(6)) bus ();

  dmem_sized #(.ADDR_W(6), .CLEAR_ON_RESET(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) mbytes[i] = 8'h00;
  endfunction

  // Little-endian byte array: n bytes starting at addr form the access.
  function automatic void model(input bit we, input logic [1:0] size, input bit sext,
                                input int addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output bit err);
    int n;
    logic [31:0] u;
    n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    rd  = 32'h0;
    err = (size == 2'd3) || (addr % n != 0);
    if (err) return;
    if (we) begin
      for (int i = 0; i < n; i++) mbytes[addr + i] = wdata[8*i +: 8];
    end else begin
      u = 32'h0;
      for (int i = 0; i < n; i++) u = u | (32'(mbytes[addr + i]) << (8 * i));
      if (sext && n < 4 && u[8*n-1]) u = u | (32'hFFFF_FFFF << (8 * n));
      rd = u;
    end
  endfunction

  task automatic check_resp();
    nchk++;
    assert (bus.resp_valid === pend_v) else begin
      nerr++;
      $error("FAIL %s resp_valid got %0b exp %0b", pend_tag, bus.resp_valid, pend_v);
    end
    if (pend_v) begin
      nchk++;
      assert (bus.resp_rdata === pend_rdata) else begin
        nerr++;
        $error("FAIL %s resp_rdata got %08h exp %08h", pend_tag, bus.resp_rdata, pend_rdata);
      end
      nchk++;
      assert (bus.resp_err === pend_err) else begin
        nerr++;
        $error("FAIL %s resp_err got %0b exp %0b", pend_tag, bus.resp_err, pend_err);
      end
    end
  endtask

  // One cycle: check the previous response, then present the next request.
  task automatic step(input bit v, input bit we, input logic [1:0] size, input bit sext,
                      input logic [5:0] addr, input logic [31:0] wdata, input string tag);
    @(negedge clk);
    check_resp();
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_sext  = sext;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    pend_v        = v;
    pend_tag      = tag;
    pend_rdata    = 32'h0;
    pend_err      = 1'b0;
    if (v) begin
      nchk++;
      assert (bus.req_ready === 1'b1) else begin
        nerr++;
        $error("FAIL %s req_ready got %0b exp 1", tag, bus.req_ready);
      end
      model(we, size, sext, int'(addr), wdata, pend_rdata, pend_err);
      $display("txn %s we=%0b sz=%0d sext=%0b addr=%02h wd=%08h exp_rd=%08h exp_err=%0b",
               tag, we, size, sext, addr, wdata, pend_rdata, pend_err);
    end
  endtask

  // Called right after rst drops at a negedge: DEPTH low-ready cycles, then RUN.
  task automatic wait_init(input string tag);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      nchk++;
      assert (bus.req_ready === 1'b0) else begin
        nerr++;
        $error("FAIL %s ready_low[%0d] got %0b exp 0", tag, i, bus.req_ready);
      end
      nchk++;
      assert (init_done === 1'b0) else begin
        nerr++;
        $error("FAIL %s init_low[%0d] got %0b exp 0", tag, i, init_done);
      end
    end
    @(negedge clk);
    #1;
    nchk++;
    assert (bus.req_ready === 1'b1) else begin
      nerr++;
      $error("FAIL %s ready_high got %0b exp 1", tag, bus.req_ready);
    end
    nchk++;
    assert (init_done === 1'b1) else begin
      nerr++;
      $error("FAIL %s init_done got %0b exp 1", tag, init_done);
    end
    model_clear();
    pend_v = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_sext  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    pend_v        = 1'b0;
    pend_tag      = "idle";
    model_clear();

    repeat (2) @(negedge clk);
    nchk++;
    assert (bus.req_ready === 1'b0) else begin nerr++; $error("FAIL rst_ready got %0b exp 0", bus.req_ready); end
    nchk++;
    assert (bus.resp_valid === 1'b0) else begin nerr++; $error("FAIL rst_valid got %0b exp 0", bus.resp_valid); end
    nchk++;
    assert (bus.resp_rdata === 32'h0) else begin nerr++; $error("FAIL rst_rdata got %08h exp 0", bus.resp_rdata); end
    nchk++;
    assert (bus.resp_err === 1'b0) else begin nerr++; $error("FAIL rst_err got %0b exp 0", bus.resp_err); end
    nchk++;
    assert (init_done === 1'b0) else begin nerr++; $error("FAIL rst_init got %0b exp 0", init_done); end
    rst = 1'b0;
    wait_init("init0");

    step(1, 0, 2'd2, 0, 6'h3C, 32'h0, "ld_w_3c");
    step(1, 1, 2'd2, 0, 6'h10, 32'h80FF7F01, "st_w_10");
    step(1, 0, 2'd0, 1, 6'h11, 32'h0, "ld_b_11_s");
    step(1, 0, 2'd0, 1, 6'h12, 32'h0, "ld_b_12_s");
    step(1, 0, 2'd0, 0, 6'h13, 32'h0, "ld_b_13_z");
    step(1, 0, 2'd1, 1, 6'h12, 32'h0, "ld_h_12_s");
    step(1, 0, 2'd1, 0, 6'h12, 32'h0, "ld_h_12_z");
    step(1, 1, 2'd2, 0, 6'h20, 32'h11223344, "st_w_20");
    step(1, 1, 2'd0, 0, 6'h21, 32'hFFFFFFAB, "st_b_21");
    step(1, 0, 2'd2, 0, 6'h20, 32'h0, "ld_w_20_a");
    step(1, 1, 2'd1, 0, 6'h22, 32'h1234BEEF, "st_h_22");
    step(1, 0, 2'd2, 0, 6'h20, 32'h0, "ld_w_20_b");
    step(1, 1, 2'd2, 0, 6'h06, 32'hCAFEF00D, "st_w_06_err");
    step(1, 0, 2'd1, 1, 6'h05, 32'h0, "ld_h_05_err");
    step(1, 1, 2'd3, 0, 6'h00, 32'h5A5A5A5A, "st_rsvd_err");
    step(1, 0, 2'd3, 0, 6'h00, 32'h0, "ld_rsvd_err");
    step(1, 0, 2'd2, 0, 6'h04, 32'h0, "ld_w_04_clean");
    step(1, 0, 2'd2, 0, 6'h00, 32'h0, "ld_w_00_clean");
    step(1, 1, 2'd2, 0, 6'h04, 32'hDEADBEEF, "st_w_04");
    step(1, 0, 2'd2, 0, 6'h04, 32'h0, "ld_w_04_fwd");
    step(0, 1, 2'd2, 0, 6'h04, 32'h12345678, "idle_junk");
    step(1, 0, 2'd2, 0, 6'h04, 32'h0, "ld_w_04_keep");

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
           2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
           6'($urandom_range(0, 63)), $urandom, "rand");
    end
    step(1, 0, 2'd2, 0, 6'h08, 32'h0, "ld_pre_rst");

    // Reset in RUN one cycle after a response appears; the next cycle is empty.
    @(negedge clk);
    check_resp();
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    pend_v        = 1'b0;
    @(negedge clk);
    nchk++;
    assert (bus.resp_valid === 1'b0) else begin nerr++; $error("FAIL run_rst_drop got %0b exp 0", bus.resp_valid); end
    nchk++;
    assert (bus.req_ready === 1'b0) else begin nerr++; $error("FAIL run_rst_ready got %0b exp 0", bus.req_ready); end
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd2;
    bus.req_addr  = 6'h08;
    @(negedge clk);
    nchk++;
    assert (bus.resp_valid === 1'b0) else begin nerr++; $error("FAIL rst_no_accept got %0b exp 0", bus.resp_valid); end
    bus.req_valid = 1'b0;
    rst = 1'b0;

    // Interrupt the clear sweep at counter 5, then expect a full sweep again.
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_init("init_restart");

    for (int i = 0; i < 16; i++) begin
      step(1, 0, 2'd2, 0, 6'(i * 4), 32'h0, "ld_cleared");
    end
    step(0, 0, 2'd0, 0, 6'h0, 32'h0, "flush");
    @(negedge clk);
    check_resp();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
